// File: rtl/prio_arb_pkg.sv
// Shared types and helpers for the priority arbiter.
package prio_arb_pkg;

    // IDLE: nothing held. HOLD: an item is presented with out_valid=1.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Upper bound on channel count; the encoder's casez table is sized for it.
    localparam int unsigned MaxChannels = 16;

    // Width of a channel index, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Rotating priority encoder: finds the first set req bit at or after start,
// wrapping around modulo N. Purely combinational.
module prio_enc
    import prio_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   start,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      found,
    output logic                      multi
);

    localparam int unsigned IdxW = idx_width(N);

    logic [N-1:0]             rot;
    logic [MaxChannels-1:0]   rot_pad;
    logic [3:0]               off;
    logic [4:0]               sum;

    // Rotate so that channel 'start' lands on bit 0, then pick the lowest set bit.
    always_comb begin
        rot     = (req >> start) | (req << (N - 32'(start)));
        rot_pad = 16'(rot);
        off     = 4'd0;
        priority casez (rot_pad)
            16'b???????????????1: off = 4'd0;
            16'b??????????????10: off = 4'd1;
            16'b?????????????100: off = 4'd2;
            16'b????????????1000: off = 4'd3;
            16'b???????????10000: off = 4'd4;
            16'b??????????100000: off = 4'd5;
            16'b?????????1000000: off = 4'd6;
            16'b????????10000000: off = 4'd7;
            16'b???????100000000: off = 4'd8;
            16'b??????1000000000: off = 4'd9;
            16'b?????10000000000: off = 4'd10;
            16'b????100000000000: off = 4'd11;
            16'b???1000000000000: off = 4'd12;
            16'b??10000000000000: off = 4'd13;
            16'b?100000000000000: off = 4'd14;
            16'b1000000000000000: off = 4'd15;
            default:              off = 4'd0;
        endcase
        // Undo the rotation: winner = (start + off) mod N.
        sum = 5'(start) + 5'(off);
        if (sum >= 5'(N)) begin
            sum = sum - 5'(N);
        end
        idx   = sum[IdxW-1:0];
        found = |req;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi = |(req & (req - N'(1)));
    end

endmodule

// File: rtl/prio_arbiter.sv
// N-channel arbiter with a one-entry registered output stage.
// Fixed priority (channel 0 highest) by default; define PRIO_ARB_ROUND_ROBIN_EN
// for rotating priority driven by a pointer that moves past each winner.
module prio_arbiter
    import prio_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              req,
    input  logic [WIDTH-1:0]          data_in [N],
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [idx_width(N)-1:0]   out_idx,
    output logic [N-1:0]              grant,
    output logic                      conflict
);

    localparam int unsigned IdxW = idx_width(N);

    arb_state_e        state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   start;
    logic [IdxW-1:0]   win;
    logic              found;
    logic              multi;
    logic              capture;

    prio_enc #(
        .N (N)
    ) u_prio_enc (
        .req   (req),
        .start (start),
        .idx   (win),
        .found (found),
        .multi (multi)
    );

    // A new item is taken when the slot is empty or being emptied this cycle.
    assign capture = !rst && found && ((state_q == IDLE) || out_ready);

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [IdxW-1:0] ptr_q, ptr_d;

    // Search for the next winner starts just past the previous one.
    always_comb begin
        ptr_d = ptr_q;
        if (capture) begin
            ptr_d = (win == IdxW'(N - 1)) ? '0 : win + IdxW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign start = ptr_q;
`else
    assign start = '0;
`endif

    // Next state, captured payload and the single-cycle grant/conflict pulses.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        grant    = '0;
        conflict = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = capture ? HOLD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            data_d     = data_in[win];
            idx_d      = win;
            grant[win] = 1'b1;
            conflict   = multi;
        end
    end

    // State and output registers; reset drops any held item.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign out_idx   = idx_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter (N=4, WIDTH=8). Honours
// PRIO_ARB_ROUND_ROBIN_EN so the reference model matches the build.
module tb_prio_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [W-1:0]   data_in [N];
    logic           out_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_idx;
    logic [N-1:0]   grant;
    logic           conflict;

    always #5 clk = ~clk;

    prio_arbiter #(
        .N     (N),
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .grant     (grant),
        .conflict  (conflict)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the output stage holds and where the search starts.
    bit             m_valid = 1'b0;
    int             m_idx   = 0;
    logic [W-1:0]   m_data  = '0;
    int             m_ptr   = 0;

    logic [N-1:0]   exp_grant;
    logic           exp_conflict;
    logic [N-1:0]   obs_grant;
    logic           obs_conflict;
    logic           obs_valid;
    logic [IW-1:0]  obs_idx;
    logic [W-1:0]   obs_data;

    // First requesting channel scanning upward from p with wrap-around.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (p + i) % N;
            if (r[c] === 1'b1) return c;
        end
        return -1;
    endfunction

    // One clock: drive at negedge, sample pulses before the edge and registers after.
    task automatic run_cycle(input logic [N-1:0] r, input logic rdy, input logic rs);
        int           w;
        bit           cap;
        logic [W-1:0] snap [N];
        req       = r;
        out_ready = rdy;
        rst       = rs;
        for (int i = 0; i < N; i++) data_in[i] = W'($urandom);
        snap = data_in;
        if ($isunknown(r)) begin
            n_checks++;
            $display("FAIL req_known: req=%b has X/Z bits", r);
        end
        #1;
        w            = pick(r, m_ptr);
        cap          = !rs && (w >= 0) && (!m_valid || rdy);
        exp_grant    = '0;
        if (cap) exp_grant[w] = 1'b1;
        exp_conflict = cap && ($countones(r) > 1);
        obs_grant    = grant;
        obs_conflict = conflict;
        @(posedge clk);
        #1;
        if (rs) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_data  = '0;
            m_ptr   = 0;
        end else if (cap) begin
            m_valid = 1'b1;
            m_idx   = w;
            m_data  = snap[w];
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            m_ptr   = (w + 1) % N;
`endif
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        obs_valid = out_valid;
        obs_idx   = out_idx;
        obs_data  = out_data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        run_cycle(4'b1111, 1'b1, 1'b1);
        run_cycle(4'b0110, 1'b0, 1'b1);
        n_checks++; if (obs_grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", obs_grant); else n_pass++;
        n_checks++; if (obs_conflict !== 1'b0) $display("FAIL rst_conflict: got %b want 0", obs_conflict); else n_pass++;
        n_checks++; if (obs_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", obs_valid); else n_pass++;
        n_checks++; if (obs_idx !== 2'd0) $display("FAIL rst_idx: got %0d want 0", obs_idx); else n_pass++;
        n_checks++; if (obs_data !== 8'h00) $display("FAIL rst_data: got %h want 00", obs_data); else n_pass++;
    endtask

    task automatic test_no_request();
        for (int c = 0; c < 5; c++) begin
            run_cycle(4'b0000, 1'($urandom), 1'b0);
            n_checks++; if (obs_grant !== 4'b0000) $display("FAIL idle_grant: cyc %0d got %b want 0000", c, obs_grant); else n_pass++;
            n_checks++; if (obs_conflict !== 1'b0) $display("FAIL idle_conflict: cyc %0d got %b want 0", c, obs_conflict); else n_pass++;
            n_checks++; if (obs_valid !== 1'b0) $display("FAIL idle_valid: cyc %0d got %b want 0", c, obs_valid); else n_pass++;
        end
    endtask

    task automatic test_fixed_priority();
        run_cycle(4'b0000, 1'b1, 1'b1);
        run_cycle(4'b0110, 1'b1, 1'b0);
        n_checks++; if (obs_grant !== 4'b0010) $display("FAIL prio_grant: got %b want 0010", obs_grant); else n_pass++;
        n_checks++; if (obs_conflict !== 1'b1) $display("FAIL prio_conflict: got %b want 1", obs_conflict); else n_pass++;
        n_checks++; if (obs_valid !== 1'b1) $display("FAIL prio_valid: got %b want 1", obs_valid); else n_pass++;
        n_checks++; if (obs_idx !== 2'd1) $display("FAIL prio_idx: got %0d want 1", obs_idx); else n_pass++;
        n_checks++; if (obs_data !== m_data) $display("FAIL prio_data: got %h want %h", obs_data, m_data); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] hold_idx;
        logic [W-1:0]  hold_data;
        run_cycle(4'(1 + $urandom_range(0, 14)), 1'b1, 1'b0);
        hold_idx  = IW'(m_idx);
        hold_data = m_data;
        for (int c = 0; c < 3; c++) begin
            run_cycle(4'(1 + $urandom_range(0, 14)), 1'b0, 1'b0);
            n_checks++; if (obs_grant !== 4'b0000) $display("FAIL bp_grant: cyc %0d got %b want 0000", c, obs_grant); else n_pass++;
            n_checks++; if (obs_valid !== 1'b1) $display("FAIL bp_valid: cyc %0d got %b want 1", c, obs_valid); else n_pass++;
            n_checks++; if (obs_idx !== hold_idx) $display("FAIL bp_idx: cyc %0d got %0d want %0d", c, obs_idx, hold_idx); else n_pass++;
            n_checks++; if (obs_data !== hold_data) $display("FAIL bp_data: cyc %0d got %h want %h", c, obs_data, hold_data); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int seq [5];
        logic [N-1:0] g;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        seq = '{0, 1, 2, 3, 0};
`else
        seq = '{0, 0, 0, 0, 0};
`endif
        run_cycle(4'b0000, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            run_cycle(4'b1111, 1'b1, 1'b0);
            g = '0;
            g[seq[c]] = 1'b1;
            n_checks++; if (obs_grant !== g) $display("FAIL b2b_grant: cyc %0d got %b want %b", c, obs_grant, g); else n_pass++;
            n_checks++; if (obs_valid !== 1'b1) $display("FAIL b2b_valid: cyc %0d got %b want 1", c, obs_valid); else n_pass++;
            n_checks++; if (obs_idx !== IW'(seq[c])) $display("FAIL b2b_idx: cyc %0d got %0d want %0d", c, obs_idx, seq[c]); else n_pass++;
        end
    endtask

    task automatic test_drain();
        run_cycle(4'b0000, 1'b1, 1'b1);
        run_cycle(4'b1000, 1'b1, 1'b0);
        n_checks++; if (obs_grant !== 4'b1000) $display("FAIL drain_grant: got %b want 1000", obs_grant); else n_pass++;
        n_checks++; if (obs_conflict !== 1'b0) $display("FAIL drain_conflict: got %b want 0", obs_conflict); else n_pass++;
        n_checks++; if (obs_valid !== 1'b1) $display("FAIL drain_valid1: got %b want 1", obs_valid); else n_pass++;
        n_checks++; if (obs_idx !== 2'd3) $display("FAIL drain_idx: got %0d want 3", obs_idx); else n_pass++;
        run_cycle(4'b0000, 1'b1, 1'b0);
        n_checks++; if (obs_grant !== 4'b0000) $display("FAIL drain_grant2: got %b want 0000", obs_grant); else n_pass++;
        n_checks++; if (obs_valid !== 1'b0) $display("FAIL drain_valid2: got %b want 0", obs_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        run_cycle(4'b0000, 1'b1, 1'b1);
        run_cycle(4'b1100, 1'b0, 1'b0);
        run_cycle(4'b0100, 1'b0, 1'b0);
        n_checks++; if (obs_valid !== 1'b1) $display("FAIL rmh_pre_valid: got %b want 1", obs_valid); else n_pass++;
        run_cycle(4'b1111, 1'b1, 1'b1);
        n_checks++; if (obs_grant !== 4'b0000) $display("FAIL rmh_grant: got %b want 0000", obs_grant); else n_pass++;
        n_checks++; if (obs_valid !== 1'b0) $display("FAIL rmh_valid: got %b want 0", obs_valid); else n_pass++;
        n_checks++; if (obs_idx !== 2'd0) $display("FAIL rmh_idx: got %0d want 0", obs_idx); else n_pass++;
        // A full request right after reset must start the search from channel 0.
        run_cycle(4'b1111, 1'b1, 1'b0);
        n_checks++; if (obs_grant !== 4'b0001) $display("FAIL rmh_ptr_grant: got %b want 0001", obs_grant); else n_pass++;
        n_checks++; if (obs_idx !== 2'd0) $display("FAIL rmh_ptr_idx: got %0d want 0", obs_idx); else n_pass++;
    endtask

    task automatic test_random();
        run_cycle(4'b0000, 1'b1, 1'b1);
        for (int c = 0; c < 300; c++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            run_cycle(r, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
            n_checks++; if (obs_grant !== exp_grant) $display("FAIL rnd_grant: cyc %0d got %b want %b", c, obs_grant, exp_grant); else n_pass++;
            n_checks++; if (obs_conflict !== exp_conflict) $display("FAIL rnd_conflict: cyc %0d got %b want %b", c, obs_conflict, exp_conflict); else n_pass++;
            n_checks++; if (obs_valid !== m_valid) $display("FAIL rnd_valid: cyc %0d got %b want %b", c, obs_valid, m_valid); else n_pass++;
            if (m_valid) begin
                n_checks++; if (obs_idx !== IW'(m_idx)) $display("FAIL rnd_idx: cyc %0d got %0d want %0d", c, obs_idx, m_idx); else n_pass++;
                n_checks++; if (obs_data !== m_data) $display("FAIL rnd_data: cyc %0d got %h want %h", c, obs_data, m_data); else n_pass++;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) data_in[i] = '0;
        @(negedge clk);
        test_reset();
        test_no_request();
        test_fixed_priority();
        test_backpressure();
        test_back_to_back();
        test_drain();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
